// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the multicycle data-memory controller.
// State encoding and default data width.
package mem_access_ctrl_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read.
// No reset; contents survive rst_n.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle data-memory controller with fixed access latency.
// Optional stored even parity per word with MEM_PARITY_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic              busy,
  output logic              addr_err
`ifdef MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef MEM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int W = DATA_W + PW;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              accept;
  logic              finish;
  logic              we;
  logic [W-1:0]      rword;
  logic [W-1:0]      wword;
  logic [AW-1:0]     req_idx;
  logic              req_err;

  assign req_idx = addr[AW+1:2];
  assign req_err = (addr[1:0] != 2'b00) ||
                   (addr[31:AW+2] != '0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read) begin
          state_d = RD_WAIT;
          cnt_d   = 4'(LATENCY - 1);
          accept  = 1'b1;
        end else if (mem_write) begin
          state_d = WR_WAIT;
          cnt_d   = 4'(LATENCY - 1);
          accept  = 1'b1;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt == 4'd0) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      // Unconditional return keeps a late-dropping mem_write from re-firing.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign we   = finish && (state == WR_WAIT) && !err_q;
  assign busy = (state != IDLE);

`ifdef MEM_PARITY_EN
  assign wword = {^wdata_q, wdata_q};
`else
  assign wword = wdata_q;
`endif

  mem_array #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (wword),
    .rdata (rword)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx       <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      read_data <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      done     <= finish;
      addr_err <= finish && err_q;
      if (accept) begin
        idx   <= req_idx;
        err_q <= req_err;
        if (!mem_read) wdata_q <= write_data;
      end
      if (finish && (state == RD_WAIT)) begin
        read_data <= err_q ? '0 : rword[DATA_W-1:0];
      end
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= finish && (state == RD_WAIT) && !err_q &&
                    ((^rword[DATA_W-1:0]) != rword[DATA_W]);
    end
  end
`endif

endmodule
